// File: rtl/divider_rate_scheduler.sv
// Purpose: round-robin arbiter sharing the frequency divider's divisor port; applies a new divisor only at a period boundary.
// Latency: grant -> ack/nack 2 cycles; ack additionally waits for the next period boundary (worst case 2+divisor_out).
// Backpressure: requesters hold req until their ack/nack pulse; ungranted requests simply wait in IDLE.
//
// Ports:
//   clock_in      clock shared with the divider
//   reset         asynchronous, active-high
//   req           per-requester request, held until ack/nack
//   req_divisor   requester i's divisor in slice [i*WIDTH +: WIDTH]
//   ack / nack    one-cycle pulses, one-hot across requesters, never both
//   divisor_out   divisor in force, drives the divider's divisor port
//   period_start  high while the tracked phase counter is 0
//   busy          high whenever the FSM is not IDLE
//   owner         index of the most recently granted requester
//
// Build option: DIVSCHED_SAME_SKIP_EN -- when defined, a legal request equal to
// the current divisor is acked straight from CHECK without waiting for a
// boundary, leaving the phase counter untouched.

module divider_rate_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int WIDTH           = 32,
   parameter int DEFAULT_DIVISOR = 2,
   parameter int MIN_DIVISOR     = 2
) (
   input  logic                       clock_in,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         nack,
   output logic [WIDTH-1:0]           divisor_out,
   output logic                       period_start,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner
);

   localparam int OW = $clog2(NUM_REQ);

   localparam logic [OW-1:0]    OWNER_RST = OW'(NUM_REQ - 1);
   localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIVISOR);
   localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(MIN_DIVISOR);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   // FSM encoding
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CHECK    = 2'd1;
   localparam logic [1:0] ST_WAIT_BND = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] pending;
   logic             boundary;

   // Unpack the flat divisor bus so a granted index can select its slice directly.
   logic [WIDTH-1:0] req_div_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_div_arr[g] = req_divisor[g*WIDTH +: WIDTH];
   end

   // divisor_out never drops below MIN_DIVISOR (>= 1), so the subtraction cannot wrap.
   assign boundary     = (phase >= (divisor_out - ONE));
   assign period_start = (phase == '0);
   assign busy         = (state != ST_IDLE);

   // ------------------------------------------------------------------------
   // Request masking: during an ack/nack pulse the served requester still has
   // req high (it drops it one cycle later), so its request is hidden for that
   // one cycle to avoid re-granting a request that has already been answered.
   // ------------------------------------------------------------------------
   logic [NUM_REQ-1:0] req_live;

   always_comb begin
      req_live = req;
      if ((ack | nack) != '0) begin
         req_live[owner] = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin search starting at owner+1, wrapping modulo NUM_REQ.
   // The loop walks from the farthest candidate back to the nearest, so the
   // last hit written is the first one in round-robin order.
   // ------------------------------------------------------------------------
   logic          grant_vld;
   logic [OW-1:0] grant_idx;
   logic [OW-1:0] scan_idx;
   int            scan;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan      = 0;
      scan_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan = int'(owner) + k;
         if (scan >= NUM_REQ) begin
            scan = scan - NUM_REQ;
         end
         scan_idx = OW'(scan);
         if (req_live[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Phase tracker: an exact copy of the divider's counter, so a divisor
   // change lands on the same edge that the divider starts a new period.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (boundary) begin
         phase <= '0;
      end else begin
         phase <= phase + ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration / apply FSM.  ack and nack are default-cleared every cycle so
   // they are single-cycle pulses.  Once latched in IDLE, the pending divisor
   // is committed: later changes to req or req_divisor are not observed.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= OWNER_RST;
         pending     <= '0;
         divisor_out <= DEF_DIV;
         ack         <= '0;
         nack        <= '0;
      end else begin
         ack  <= '0;
         nack <= '0;
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  owner   <= grant_idx;
                  pending <= req_div_arr[grant_idx];
                  state   <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (pending < MIN_DIV) begin
                  nack[owner] <= 1'b1;
                  state       <= ST_IDLE;
               end
`ifdef DIVSCHED_SAME_SKIP_EN
               else if (pending == divisor_out) begin
                  // Nothing changes at the divider, so no need to wait for a
                  // boundary; the phase keeps running undisturbed.
                  ack[owner] <= 1'b1;
                  state      <= ST_IDLE;
               end
`endif
               else begin
                  state <= ST_WAIT_BND;
               end
            end

            ST_WAIT_BND: begin
               // The phase counter already returns to 0 on a boundary, so the
               // new divisor governs the period that begins at this edge.
               if (boundary) begin
                  divisor_out <= pending;
                  ack[owner]  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_rate_scheduler.sv
// Purpose: scoreboard bench for divider_rate_scheduler with directed, hand-timed vectors.
// Latency: expected response cycle numbers are computed by hand from the phase at issue time.
// Backpressure: each requester holds req through its ack/nack cycle and drops it one cycle later.

module tb_divider_rate_scheduler;

   logic        clock_in;
   logic        reset;
   logic [3:0]  req;
   logic [127:0] req_divisor;
   logic [3:0]  ack;
   logic [3:0]  nack;
   logic [31:0] divisor_out;
   logic        period_start;
   logic        busy;
   logic [1:0]  owner;

   logic [31:0] div_arr [4];
   assign req_divisor = {div_arr[3], div_arr[2], div_arr[1], div_arr[0]};

   divider_rate_scheduler #(
      .NUM_REQ(4), .WIDTH(32), .DEFAULT_DIVISOR(2), .MIN_DIVISOR(2)
   ) dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .req         (req),
      .req_divisor (req_divisor),
      .ack         (ack),
      .nack        (nack),
      .divisor_out (divisor_out),
      .period_start(period_start),
      .busy        (busy),
      .owner       (owner)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   // Posedge count; read at negedges, where it is stable.
   int cyc = 0;
   always @(posedge clock_in) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  ack_v;
      logic [3:0]  nack_v;
      logic [31:0] div;
      int          at_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] idx, input bit is_ack, input logic [31:0] div, input int at);
      exp_t e;
      e.ack_v  = 4'b0;
      e.nack_v = 4'b0;
      if (is_ack) e.ack_v[idx] = 1'b1;
      else        e.nack_v[idx] = 1'b1;
      e.div    = div;
      e.at_cyc = at;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [1:0] idx, input logic [31:0] div);
      div_arr[idx] = div;
      req[idx]     = 1'b1;
   endtask

   // Waits for an ack/nack on every bit of who, dropping each req one negedge
   // after its response so the DUT sees it high during the response cycle.
   task automatic serve(input logic [3:0] who);
      logic [3:0] done_v;
      logic [3:0] drop_nxt;
      int n;
      done_v   = 4'b0;
      drop_nxt = 4'b0;
      n        = 0;
      while ((done_v != who || drop_nxt != 4'b0) && n < 60) begin
         @(negedge clock_in);
         n++;
         req      = req & ~drop_nxt;
         drop_nxt = (ack | nack) & who & ~done_v;
         done_v   = done_v | drop_nxt;
      end
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL serve_timeout: served=%b required=%b", done_v, who);
         req = req & ~who;
      end
   endtask

   task automatic wait_ps();
      int n;
      n = 0;
      do begin
         @(negedge clock_in);
         n++;
      end while (!period_start && n < 30);
      if (!period_start) begin
         total++;
         bad++;
         $display("FAIL wait_period_start: period_start=%0d required=1 after %0d cycles", period_start, n);
      end
   endtask

   // Monitor: every response the DUT presents must match the oldest expectation.
   initial begin : monitor
      forever begin
         @(negedge clock_in);
         if (!reset && (ack | nack) != 4'b0) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: ack=%b nack=%b, required none outstanding", ack, nack);
            end else begin
               mon_e = sb.pop_front();
               check("resp_ack",  32'(ack),  32'(mon_e.ack_v));
               check("resp_nack", 32'(nack), 32'(mon_e.nack_v));
               check("resp_div",  divisor_out, mon_e.div);
               check("resp_cyc",  32'(cyc), 32'(mon_e.at_cyc));
            end
         end
      end
   end

   initial begin : stimulus
      int c;
      int exp_ps;
      reset = 1'b1;
      req   = 4'b0;
      for (int i = 0; i < 4; i++) div_arr[i] = 32'd0;

      // Reset values
      @(negedge clock_in);
      check("rst_div",   divisor_out, 32'd2);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd3);
      check("rst_ack",   32'(ack), 32'd0);
      check("rst_nack",  32'(nack), 32'd0);
      check("rst_ps",    32'(period_start), 32'd1);
      reset = 1'b0;

      // Idle, divisor 2: period_start every second cycle
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock_in);
         exp_ps = ((k % 2) == 0) ? 1 : 0;
         check("idle_ps",   32'(period_start), 32'(exp_ps));
         check("idle_busy", 32'(busy), 32'd0);
      end

      // Requester 1 asks for 10 at phase 0 of a divide-by-2 period
      wait_ps();
      c = cyc;
      issue(2'd1, 32'd10);
      push(2'd1, 1'b1, 32'd10, c + 4);
      serve(4'b0010);
      wait_ps();
      check("period_len", 32'(cyc), 32'(c + 14));
      check("div_after_10", divisor_out, 32'd10);

      // Requester 3 asks for an illegal divisor
      c = cyc;
      issue(2'd3, 32'd1);
      push(2'd3, 1'b0, 32'd10, c + 2);
      serve(4'b1000);
      check("nack_owner", 32'(owner), 32'd3);
      check("nack_div",   divisor_out, 32'd10);

      // Requester 0 asks for 4, leaving owner=0
      wait_ps();
      c = cyc;
      issue(2'd0, 32'd4);
      push(2'd0, 1'b1, 32'd4, c + 10);
      serve(4'b0001);
      check("owner0", 32'(owner), 32'd0);

      // Requesters 0 and 2 together with owner=0: 2 wins, then 0
      wait_ps();
      c = cyc;
      issue(2'd0, 32'd3);
      issue(2'd2, 32'd6);
      push(2'd2, 1'b1, 32'd6, c + 4);
      push(2'd0, 1'b1, 32'd3, c + 10);
      serve(4'b0101);
      check("rr_owner", 32'(owner), 32'd0);
      check("rr_div",   divisor_out, 32'd3);

      // Equal divisor requested mid-period (phase 1 of 3)
      wait_ps();
      @(negedge clock_in);
      c = cyc;
      issue(2'd1, 32'd3);
`ifdef DIVSCHED_SAME_SKIP_EN
      push(2'd1, 1'b1, 32'd3, c + 2);
`else
      push(2'd1, 1'b1, 32'd3, c + 5);
`endif
      serve(4'b0010);
      check("same_owner", 32'(owner), 32'd1);

      // Reset while waiting for the boundary: request discarded silently
      wait_ps();
      @(negedge clock_in);
      issue(2'd2, 32'd7);
      repeat (3) @(negedge clock_in);
      check("wait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_div",   divisor_out, 32'd2);
      check("mid_rst_busy",  32'(busy), 32'd0);
      check("mid_rst_owner", 32'(owner), 32'd3);
      check("mid_rst_ack",   32'(ack), 32'd0);
      @(negedge clock_in);
      reset = 1'b0;
      req   = 4'b0;
      repeat (12) @(negedge clock_in);
      check("post_rst_div",  divisor_out, 32'd2);
      check("post_rst_busy", 32'(busy), 32'd0);

      while (sb.size() != 0) begin
         mon_e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL missing_resp: ack=%b nack=%b due cyc %0d never seen", mon_e.ack_v, mon_e.nack_v, mon_e.at_cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
